// File: rtl/display_pkg.sv
// display_pkg: shared types, segment patterns and hex decode for display blocks
package display_pkg;
   localparam int NUM_DIGITS = 4;
   typedef logic [NUM_DIGITS-1:0] digit_sel_t;
   typedef logic [6:0] seg_t;
   localparam seg_t SEG_0   = 7'b1000000;
   localparam seg_t SEG_1   = 7'b1111001;
   localparam seg_t SEG_2   = 7'b0100100;
   localparam seg_t SEG_3   = 7'b0110000;
   localparam seg_t SEG_4   = 7'b0011001;
   localparam seg_t SEG_5   = 7'b0010010;
   localparam seg_t SEG_6   = 7'b0000010;
   localparam seg_t SEG_7   = 7'b1111000;
   localparam seg_t SEG_8   = 7'b0000000;
   localparam seg_t SEG_9   = 7'b0010000;
   localparam seg_t SEG_A   = 7'b0001000;
   localparam seg_t SEG_B   = 7'b0000011;
   localparam seg_t SEG_C   = 7'b1000110;
   localparam seg_t SEG_D   = 7'b0100001;
   localparam seg_t SEG_E   = 7'b0000110;
   localparam seg_t SEG_F   = 7'b0001110;
   localparam seg_t SEG_OFF = 7'b1111111;

   function automatic seg_t hex_to_seg(input logic [3:0] n);
      case (n)
         4'h0:    return SEG_0;
         4'h1:    return SEG_1;
         4'h2:    return SEG_2;
         4'h3:    return SEG_3;
         4'h4:    return SEG_4;
         4'h5:    return SEG_5;
         4'h6:    return SEG_6;
         4'h7:    return SEG_7;
         4'h8:    return SEG_8;
         4'h9:    return SEG_9;
         4'hA:    return SEG_A;
         4'hB:    return SEG_B;
         4'hC:    return SEG_C;
         4'hD:    return SEG_D;
         4'hE:    return SEG_E;
         default: return SEG_F;
      endcase
   endfunction
endpackage

// File: rtl/display_scanner_if.sv
// display_scanner_if: control/data inputs and display drive outputs of the scanner
interface display_scanner_if;
   import display_pkg::*;
   logic       enable;
   logic [15:0] data_in;
   logic [3:0] dp_in;
   logic       load;
   logic       load_ack;
   digit_sel_t sel;
   logic [3:0] an;
   seg_t       seg;
   logic       dp;
   logic       frame_done;
   modport master (
      output enable, data_in, dp_in, load,
      input  load_ack, sel, an, seg, dp, frame_done
   );
   modport slave (
      input  enable, data_in, dp_in, load,
      output load_ack, sel, an, seg, dp, frame_done
   );
endinterface

// File: rtl/seg_decoder.sv
// seg_decoder: combinational hex nibble to active-low seven-segment pattern
module seg_decoder
   import display_pkg::*;
(
   input  logic [3:0] i_nibble,
   output seg_t       o_seg
);
   assign o_seg = hex_to_seg(i_nibble);
endmodule

// File: rtl/display_scanner.sv
// display_scanner: four-digit seven-segment scan driver with dead time, blanking and frame-aligned loads
module display_scanner
   import display_pkg::*;
#(
   parameter int REFRESH_DIV   = 100000,
   parameter int DEAD_CYCLES   = 4,
   parameter int BLANK_LEADING = 1
) (
   input logic              clk,
   input logic              reset_n,
   display_scanner_if.slave bus
);
   localparam int PW = $clog2(REFRESH_DIV);

   logic [PW-1:0] r_pcnt, w_pcnt_n;
   digit_sel_t    r_sel, w_sel_n;
   logic [15:0]   r_disp, r_shadow, w_disp_n;
   logic          r_pending, r_load_ack, r_frame_done, r_dp;
   logic [3:0]    r_an, w_an_n, w_blank, w_nib;
   seg_t          r_seg, w_seg;
   logic [1:0]    w_idx;
   logic          w_tick, w_bnd;

   // Next scan position and display value; outputs are registered from these so sel/an/seg/dp move together
   always_comb begin
      w_tick   = bus.enable && (r_pcnt == PW'(REFRESH_DIV - 1));
      w_bnd    = w_tick && r_sel[3];
      w_pcnt_n = (!bus.enable || w_tick) ? '0 : r_pcnt + 1'b1;
      w_sel_n  = w_tick ? {r_sel[2:0], r_sel[3]} : r_sel;
      w_disp_n = (w_bnd && r_pending) ? r_shadow : r_disp;
      w_idx    = w_sel_n[3] ? 2'd3 : w_sel_n[2] ? 2'd2 : w_sel_n[1] ? 2'd1 : 2'd0;
      w_nib    = w_disp_n[{w_idx, 2'b00} +: 4];
      w_blank  = {~|w_disp_n[15:12], ~|w_disp_n[15:8], ~|w_disp_n[15:4], 1'b0} & {4{BLANK_LEADING != 0}};
      w_an_n   = (!bus.enable || (w_pcnt_n < PW'(DEAD_CYCLES)) || w_blank[w_idx]) ? 4'hF : ~w_sel_n;
   end

   seg_decoder u_dec (
      .i_nibble(w_nib),
      .o_seg   (w_seg)
   );

   // Scan state, shadow/pending load path and registered display outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pcnt       <= '0;
         r_sel        <= 4'b0001;
         r_disp       <= '0;
         r_shadow     <= '0;
         r_pending    <= 1'b0;
         r_an         <= 4'hF;
         r_seg        <= SEG_OFF;
         r_dp         <= 1'b1;
         r_load_ack   <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_pcnt       <= w_pcnt_n;
         r_sel        <= w_sel_n;
         r_disp       <= w_disp_n;
         r_shadow     <= bus.load ? bus.data_in : r_shadow;
         r_pending    <= bus.load || (r_pending && !w_bnd);
         r_an         <= w_an_n;
         r_seg        <= w_seg;
         r_dp         <= ~bus.dp_in[w_idx];
         r_load_ack   <= w_bnd && r_pending;
         r_frame_done <= w_bnd;
      end
   end

   assign bus.sel        = r_sel;
   assign bus.an         = r_an;
   assign bus.seg        = r_seg;
   assign bus.dp         = r_dp;
   assign bus.load_ack   = r_load_ack;
   assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_display_scanner.sv
// tb_display_scanner: reference-model and directed checks of the display scanner
module tb_display_scanner;
   localparam int RD = 8;
   localparam int DC = 2;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   display_scanner_if bus ();

   display_scanner #(.REFRESH_DIV(RD), .DEAD_CYCLES(DC), .BLANK_LEADING(1)) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   int n_chk = 0;
   int n_pass = 0;

   logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   int          m_pos, m_dig;
   logic [15:0] m_disp, m_shadow;
   bit          m_pend, m_bnd, m_blank;
   logic [3:0]  e_sel, e_an, m_nib;
   logic [6:0]  e_seg;
   logic        e_dp, e_ack, e_fd;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: slot position and digit counted arithmetically, loads kept as shadow/pending
   initial forever begin
      @(posedge clk);
      if (!reset_n) begin
         m_pos = 0; m_dig = 0; m_disp = 0; m_shadow = 0; m_pend = 0;
         e_sel = 4'b0001; e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_ack = 1'b0; e_fd = 1'b0;
      end else begin
         m_bnd = bus.enable && m_pos == RD - 1 && m_dig == 3;
         e_fd  = m_bnd;
         e_ack = m_bnd && m_pend;
         if (e_ack) begin
            m_disp = m_shadow;
            m_pend = 0;
         end
         if (bus.load) begin
            m_shadow = bus.data_in;
            m_pend = 1;
         end
         if (!bus.enable) m_pos = 0;
         else if (m_pos == RD - 1) begin
            m_pos = 0;
            m_dig = (m_dig + 1) % 4;
         end else m_pos++;
         m_nib   = 4'(m_disp >> (4 * m_dig));
         m_blank = m_dig > 0 && (m_disp >> (4 * m_dig)) == 16'd0;
         e_sel   = 4'(1 << m_dig);
         e_seg   = seg_tbl[m_nib];
         e_an    = (!bus.enable || m_pos < DC || m_blank) ? 4'hF : ~e_sel;
         e_dp    = ~bus.dp_in[m_dig];
      end
      #1;
      check("sel", 32'(bus.sel), 32'(e_sel));
      check("an", 32'(bus.an), 32'(e_an));
      check("seg", 32'(bus.seg), 32'(e_seg));
      check("dp", 32'(bus.dp), 32'(e_dp));
      check("load_ack", 32'(bus.load_ack), 32'(e_ack));
      check("frame_done", 32'(bus.frame_done), 32'(e_fd));
   end

   initial begin
      bus.dp_in = 4'($urandom);
      forever begin
         @(negedge clk);
         bus.dp_in = 4'($urandom);
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_load(input logic [15:0] v);
      bus.data_in = v;
      bus.load = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
   endtask

   task automatic wait_fd();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.frame_done) break;
      end
      check("fd_seen", 32'(bus.frame_done), 32'd1);
   endtask

   task automatic count_acks(input int n, output int acks);
      acks = 0;
      repeat (n) begin
         @(negedge clk);
         if (bus.load_ack) acks++;
      end
   endtask

   int acks, lat;
   logic [3:0] s;

   initial begin
      bus.enable = 1'b0;
      bus.load = 1'b0;
      bus.data_in = '0;
      step(5);
      check("rst_sel", 32'(bus.sel), 32'h1);
      check("rst_an", 32'(bus.an), 32'hF);
      check("rst_seg", 32'(bus.seg), 32'h7F);
      check("rst_dp", 32'(bus.dp), 32'h1);
      reset_n = 1'b1;
      bus.enable = 1'b1;
      step(1);
      check("dead_an", 32'(bus.an), 32'hF);
      step(1);
      check("live_an", 32'(bus.an), 32'hE);
      check("zero_seg", 32'(bus.seg), 32'h40);
      step(6);
      check("sel_d1", 32'(bus.sel), 32'h2);
      step(24);
      check("fd_32", 32'(bus.frame_done), 32'h1);
      check("sel_wrap", 32'(bus.sel), 32'h1);
      step(32);
      check("fd_64", 32'(bus.frame_done), 32'h1);

      do_load(16'h12A4);
      wait_fd();
      check("ack_12a4", 32'(bus.load_ack), 32'h1);
      check("d0_seg4", 32'(bus.seg), 32'h19);
      check("d0_dead", 32'(bus.an), 32'hF);
      step(2);
      check("d0_an", 32'(bus.an), 32'hE);
      step(8);
      check("d1_segA", 32'(bus.seg), 32'h08);
      check("d1_an", 32'(bus.an), 32'hD);

      do_load(16'h0050);
      wait_fd();
      step(18);
      check("lz_d2", 32'(bus.an), 32'hF);
      do_load(16'h0000);
      wait_fd();
      step(10);
      check("zero_d1", 32'(bus.an), 32'hF);

      do_load(16'h1111);
      step(3);
      do_load(16'h2222);
      wait_fd();
      check("b2b_ack", 32'(bus.load_ack), 32'h1);
      check("b2b_seg2", 32'(bus.seg), 32'h24);
      count_acks(40, acks);
      check("b2b_single", 32'(acks), 32'd0);

      wait_fd();
      step(31);
      bus.data_in = 16'hBEEF;
      bus.load = 1'b1;
      step(1);
      bus.load = 1'b0;
      check("bnd_fd", 32'(bus.frame_done), 32'h1);
      check("bnd_noack", 32'(bus.load_ack), 32'h0);
      lat = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         lat++;
         if (bus.load_ack) break;
      end
      check("bnd_lat", 32'(lat), 32'd32);

      step(10);
      s = bus.sel;
      bus.enable = 1'b0;
      step(5);
      check("dis_an", 32'(bus.an), 32'hF);
      check("dis_sel", 32'(bus.sel), 32'(s));
      bus.enable = 1'b1;
      step(RD - 1);
      check("res_sel", 32'(bus.sel), 32'(s));
      step(1);
      check("res_next", 32'(bus.sel), 32'({s[2:0], s[3]}));

      do_load(16'h3333);
      step(3);
      reset_n = 1'b0;
      step(2);
      check("mrst_sel", 32'(bus.sel), 32'h1);
      check("mrst_an", 32'(bus.an), 32'hF);
      reset_n = 1'b1;
      count_acks(80, acks);
      check("mrst_noack", 32'(acks), 32'd0);

      for (int i = 0; i < 1500; i++) begin
         bus.load = ($urandom_range(0, 19) == 0);
         bus.data_in = 16'($urandom);
         if ($urandom_range(0, 29) == 0) bus.enable = ~bus.enable;
         step(1);
      end
      bus.load = 1'b0;
      step(2);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
